// File: rtl/conv_maxpool_if.sv
// Request/response bundle for conv_maxpool: start/finish handshake,
// source BRAM port M0 and destination BRAM port M1.
interface conv_maxpool_if;
    logic        start;
    logic        finish;
    logic        M0_R_req;
    logic [31:0] M0_addr;
    logic [31:0] M0_R_data;
    logic [3:0]  M0_W_req;
    logic [31:0] M0_W_data;
    logic        M1_R_req;
    logic [31:0] M1_addr;
    logic [31:0] M1_R_data;
    logic [3:0]  M1_W_req;
    logic [31:0] M1_W_data;

    // The pooling engine masters both BRAM ports.
    modport master (
        input  start, M0_R_data, M1_R_data,
        output finish, M0_R_req, M0_addr, M0_W_req, M0_W_data,
               M1_R_req, M1_addr, M1_W_req, M1_W_data
    );

    // Controller / memory side.
    modport slave (
        output start, M0_R_data, M1_R_data,
        input  finish, M0_R_req, M0_addr, M0_W_req, M0_W_data,
               M1_R_req, M1_addr, M1_W_req, M1_W_data
    );
endinterface

// File: rtl/conv_maxpool.sv
// 2x2 stride-2 signed max pooling over a feature map held in a source BRAM,
// with optional ReLU, writing the pooled map to a destination BRAM.
// Each window takes six cycles: four reads, one drain cycle, one write.
module conv_maxpool #(
    parameter int IMG_W    = 64,
    parameter int IMG_H    = 64,
    parameter int IN_BASE  = 0,
    parameter int OUT_BASE = 0,
    parameter int RELU     = 0
) (
    input logic            clk,
    input logic            rst,
    conv_maxpool_if.master bus
);
    localparam int OW = IMG_W / 2;
    localparam int OH = IMG_H / 2;

    typedef enum logic [2:0] {IDLE, RD, LAST, WR, DONE} state_t;

    state_t      state, state_n;
    logic [1:0]  k, k_n;
    logic [15:0] ox, ox_n, oy, oy_n;
    logic [31:0] max_val, max_n;
    logic [31:0] bigger;
    logic        finish_q, finish_n;
    logic        rreq_q, rreq_n;
    logic [31:0] raddr_q, raddr_n;
    logic [3:0]  wreq_q, wreq_n;
    logic [31:0] waddr_q, waddr_n;
    logic [31:0] wdata_q, wdata_n;
    logic        unused_m1_rdata;

    // Source address of window element kk for output pixel (x, y).
    function automatic logic [31:0] rd_addr(input logic [15:0] x, input logic [15:0] y,
                                            input logic [1:0] kk);
        logic [31:0] row;
        row = 32'({y, 1'b0}) + 32'(kk[1]);
        return 32'(IN_BASE) + row * 32'(IMG_W) + 32'({x, 1'b0}) + 32'(kk[0]);
    endfunction

    // State, counters and all registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            ox       <= '0;
            oy       <= '0;
            max_val  <= '0;
            finish_q <= 1'b0;
            rreq_q   <= 1'b0;
            raddr_q  <= '0;
            wreq_q   <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state    <= state_n;
            k        <= k_n;
            ox       <= ox_n;
            oy       <= oy_n;
            max_val  <= max_n;
            finish_q <= finish_n;
            rreq_q   <= rreq_n;
            raddr_q  <= raddr_n;
            wreq_q   <= wreq_n;
            waddr_q  <= waddr_n;
            wdata_q  <= wdata_n;
        end
    end

    // Next-state logic; read data arriving this cycle belongs to element k-1.
    always_comb begin
        state_n  = state;
        k_n      = k;
        ox_n     = ox;
        oy_n     = oy;
        max_n    = max_val;
        finish_n = finish_q;
        rreq_n   = 1'b0;
        raddr_n  = raddr_q;
        wreq_n   = 4'h0;
        waddr_n  = waddr_q;
        wdata_n  = wdata_q;
        bigger   = ($signed(bus.M0_R_data) > $signed(max_val)) ? bus.M0_R_data : max_val;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n  = RD;
                    k_n      = 2'd0;
                    ox_n     = '0;
                    oy_n     = '0;
                    finish_n = 1'b0;
                    rreq_n   = 1'b1;
                    raddr_n  = rd_addr(16'd0, 16'd0, 2'd0);
                end
            end
            RD: begin
                if (k == 2'd1) begin
                    max_n = bus.M0_R_data;
                end else if (k != 2'd0) begin
                    max_n = bigger;
                end
                if (k == 2'd3) begin
                    state_n = LAST;
                end else begin
                    k_n     = k + 2'd1;
                    rreq_n  = 1'b1;
                    raddr_n = rd_addr(ox, oy, k_n);
                end
            end
            LAST: begin
                max_n   = bigger;
                state_n = WR;
                wreq_n  = 4'hF;
                waddr_n = 32'(OUT_BASE) + 32'(oy) * 32'(OW) + 32'(ox);
                wdata_n = (RELU != 0 && bigger[31]) ? 32'h0 : bigger;
            end
            WR: begin
                if (ox == 16'(OW - 1) && oy == 16'(OH - 1)) begin
                    state_n  = DONE;
                    finish_n = 1'b1;
                end else begin
                    if (ox == 16'(OW - 1)) begin
                        ox_n = '0;
                        oy_n = oy + 16'd1;
                    end else begin
                        ox_n = ox + 16'd1;
                    end
                    state_n = RD;
                    k_n     = 2'd0;
                    rreq_n  = 1'b1;
                    raddr_n = rd_addr(ox_n, oy_n, 2'd0);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.finish    = finish_q;
    assign bus.M0_R_req  = rreq_q;
    assign bus.M0_addr   = raddr_q;
    assign bus.M0_W_req  = 4'h0;
    assign bus.M0_W_data = 32'h0;
    assign bus.M1_R_req  = 1'b0;
    assign bus.M1_addr   = waddr_q;
    assign bus.M1_W_req  = wreq_q;
    assign bus.M1_W_data = wdata_q;

    assign unused_m1_rdata = ^bus.M1_R_data;
endmodule

// File: tb/tb_conv_maxpool.sv
// Directed bench for conv_maxpool: four instances with different geometry
// share one source and one destination memory model; only one runs at a time.
module tb_conv_maxpool;
    localparam logic [31:0] SENT = 32'hDEADBEEF;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [3:0]  start_v;
    logic [31:0] rdata;

    logic        rq  [4];
    logic [31:0] ra  [4];
    logic [3:0]  wq  [4];
    logic [31:0] wa  [4];
    logic [31:0] wd  [4];
    logic        fin [4];
    logic [3:0]  w0q [4];
    logic        r1q [4];

    logic [31:0] m0 [0:4351];
    logic [31:0] m1 [0:1099];
    logic [31:0] gold [0:1023];
    logic [31:0] rd_log [0:15];
    int          rd_count;
    int          wr_count;
    int          port_clash;

    int tests;
    int fails;
    int cyc;

    conv_maxpool_if bus[4] ();

    conv_maxpool #(.IMG_W(4), .IMG_H(4), .IN_BASE(0), .OUT_BASE(0), .RELU(0))
        u_a (.clk(clk), .rst(rst), .bus(bus[0]));
    conv_maxpool #(.IMG_W(4), .IMG_H(4), .IN_BASE(0), .OUT_BASE(0), .RELU(1))
        u_b (.clk(clk), .rst(rst), .bus(bus[1]));
    conv_maxpool #(.IMG_W(8), .IMG_H(4), .IN_BASE(100), .OUT_BASE(50), .RELU(0))
        u_c (.clk(clk), .rst(rst), .bus(bus[2]));
    conv_maxpool #(.IMG_W(64), .IMG_H(64), .IN_BASE(0), .OUT_BASE(0), .RELU(0))
        u_d (.clk(clk), .rst(rst), .bus(bus[3]));

    for (genvar g = 0; g < 4; g++) begin : g_tap
        assign rq[g]  = bus[g].M0_R_req;
        assign ra[g]  = bus[g].M0_addr;
        assign wq[g]  = bus[g].M1_W_req;
        assign wa[g]  = bus[g].M1_addr;
        assign wd[g]  = bus[g].M1_W_data;
        assign fin[g] = bus[g].finish;
        assign w0q[g] = bus[g].M0_W_req;
        assign r1q[g] = bus[g].M1_R_req;
        assign bus[g].start     = start_v[g];
        assign bus[g].M0_R_data = rdata;
        assign bus[g].M1_R_data = 32'h0;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared BRAM model: one-cycle read latency, word writes, activity counters.
    always @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < 1100; i++) m1[i] <= SENT;
            rd_count   <= 0;
            wr_count   <= 0;
            port_clash <= 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (rq[i]) begin
                    rdata <= m0[ra[i]];
                    rd_count <= rd_count + 1;
                    if (rd_count < 16) rd_log[rd_count] <= ra[i];
                end
                if (wq[i] == 4'hF) begin
                    m1[wa[i]] <= wd[i];
                    wr_count <= wr_count + 1;
                end
                if (rq[i] && wq[i] != 4'h0) port_clash <= port_clash + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Pulse start on instance g; afterwards the bench sits in cycle 1.
    task automatic applyStimulus(input int g);
        start_v[g] = 1'b1;
        @(posedge clk);
        #1;
        start_v[g] = 1'b0;
        cyc = 1;
    endtask

    task automatic clearMem();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic waitFinish(input int g, input int bound);
        while (fin[g] !== 1'b1 && cyc < bound) tick();
    endtask

    initial begin
        logic [31:0] e0, e1, e2, e3, mx;
        tests   = 0;
        fails   = 0;
        cyc     = 0;
        rst     = 1'b1;
        clear   = 1'b0;
        start_v = 4'h0;
        for (int i = 0; i < 4352; i++) m0[i] = 32'h0;

        // Reset values
        tick();
        tick();
        checkOutput("rst_finish",   {31'h0, fin[0]}, 32'h0);
        checkOutput("rst_m0_req",   {31'h0, rq[0]},  32'h0);
        checkOutput("rst_m1_req",   {28'h0, wq[0]},  32'h0);
        checkOutput("rst_m0_addr",  ra[0], 32'h0);
        checkOutput("rst_m1_addr",  wa[0], 32'h0);
        checkOutput("rst_m1_data",  wd[0], 32'h0);
        checkOutput("rst_tied",     {27'h0, r1q[0], w0q[0]}, 32'h0);
        rst = 1'b0;
        clearMem();

        // 4x4 ramp
        for (int i = 0; i < 16; i++) m0[i] = i;
        applyStimulus(0);
        checkOutput("ramp_first_addr", ra[0], 32'd0);
        waitFinish(0, 100);
        checkOutput("ramp_finish_cycle", cyc, 25);
        checkOutput("ramp_m1_0", m1[0], 32'd5);
        checkOutput("ramp_m1_1", m1[1], 32'd7);
        checkOutput("ramp_m1_2", m1[2], 32'd13);
        checkOutput("ramp_m1_3", m1[3], 32'd15);
        checkOutput("ramp_reads",  rd_count, 16);
        checkOutput("ramp_writes", wr_count, 4);

        // Back-to-back restart with a start pulse while busy
        tick();
        checkOutput("finish_held_idle", {31'h0, fin[0]}, 32'h1);
        applyStimulus(0);
        checkOutput("finish_drop", {31'h0, fin[0]}, 32'h0);
        while (cyc < 10) tick();
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        waitFinish(0, 100);
        checkOutput("busy_start_finish_cycle", cyc, 25);
        checkOutput("restart_m1_3", m1[3], 32'd15);
        checkOutput("restart_writes", wr_count, 8);
        checkOutput("ramp_no_clash", port_clash, 0);

        // Reset in the middle of a pass
        tick();
        clearMem();
        applyStimulus(0);
        while (cyc < 20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midrst_m0_req", {31'h0, rq[0]}, 32'h0);
        checkOutput("midrst_m1_req", {28'h0, wq[0]}, 32'h0);
        checkOutput("midrst_finish", {31'h0, fin[0]}, 32'h0);
        checkOutput("midrst_m1_2", m1[2], 32'd13);
        checkOutput("midrst_m1_3", m1[3], SENT);
        tick();
        checkOutput("midrst_writes", wr_count, 3);
        applyStimulus(0);
        waitFinish(0, 100);
        checkOutput("midrst_rerun_cycle", cyc, 25);
        checkOutput("midrst_rerun_m1_0", m1[0], 32'd5);
        checkOutput("midrst_rerun_m1_3", m1[3], 32'd15);

        // Signed compare, RELU off then on
        m0[0]  = 32'hFFFFFFFE; m0[1]  = 32'hFFFFFFFF; m0[4]  = 32'h80000000; m0[5]  = 32'hFFFFFFF0;
        m0[2]  = 32'h80000000; m0[3]  = 32'h7FFFFFFF; m0[6]  = 32'h00000000; m0[7]  = 32'h00000005;
        m0[8]  = 32'h80000000; m0[9]  = 32'h80000000; m0[12] = 32'h80000000; m0[13] = 32'h80000000;
        m0[10] = 32'hFFFFFFFF; m0[11] = 32'h00000001; m0[14] = 32'h80000000; m0[15] = 32'hFFFFFFFF;
        tick();
        clearMem();
        applyStimulus(0);
        waitFinish(0, 100);
        checkOutput("signed_neg_max",  m1[0], 32'hFFFFFFFF);
        checkOutput("signed_extremes", m1[1], 32'h7FFFFFFF);
        checkOutput("signed_all_min",  m1[2], 32'h80000000);
        checkOutput("signed_mixed",    m1[3], 32'h00000001);
        tick();
        clearMem();
        applyStimulus(1);
        waitFinish(1, 100);
        checkOutput("relu_finish_cycle", cyc, 25);
        checkOutput("relu_neg_max",  m1[0], 32'h00000000);
        checkOutput("relu_extremes", m1[1], 32'h7FFFFFFF);
        checkOutput("relu_all_min",  m1[2], 32'h00000000);
        checkOutput("relu_mixed",    m1[3], 32'h00000001);

        // Address walk: 8x4 map at IN_BASE 100, output at OUT_BASE 50
        for (int i = 0; i < 32; i++) m0[100 + i] = 3 * i;
        tick();
        clearMem();
        applyStimulus(2);
        waitFinish(2, 200);
        checkOutput("walk_finish_cycle", cyc, 49);
        checkOutput("walk_rd0", rd_log[0], 32'd100);
        checkOutput("walk_rd1", rd_log[1], 32'd101);
        checkOutput("walk_rd2", rd_log[2], 32'd108);
        checkOutput("walk_rd3", rd_log[3], 32'd109);
        checkOutput("walk_rd4", rd_log[4], 32'd102);
        checkOutput("walk_rd5", rd_log[5], 32'd103);
        checkOutput("walk_rd6", rd_log[6], 32'd110);
        checkOutput("walk_rd7", rd_log[7], 32'd111);
        for (int oy = 0; oy < 2; oy++)
            for (int ox = 0; ox < 4; ox++)
                checkOutput($sformatf("walk_m1_%0d", 50 + oy * 4 + ox), m1[50 + oy * 4 + ox],
                            32'(3 * ((2 * oy + 1) * 8 + 2 * ox + 1)));
        checkOutput("walk_m1_49", m1[49], SENT);
        checkOutput("walk_m1_58", m1[58], SENT);

        // Full 64x64 against a golden model
        for (int i = 0; i < 4096; i++) m0[i] = $urandom;
        for (int oy = 0; oy < 32; oy++) begin
            for (int ox = 0; ox < 32; ox++) begin
                e0 = m0[(2 * oy) * 64 + 2 * ox];
                e1 = m0[(2 * oy) * 64 + 2 * ox + 1];
                e2 = m0[(2 * oy + 1) * 64 + 2 * ox];
                e3 = m0[(2 * oy + 1) * 64 + 2 * ox + 1];
                mx = e0;
                if ($signed(e1) > $signed(mx)) mx = e1;
                if ($signed(e2) > $signed(mx)) mx = e2;
                if ($signed(e3) > $signed(mx)) mx = e3;
                gold[oy * 32 + ox] = mx;
            end
        end
        tick();
        clearMem();
        applyStimulus(3);
        waitFinish(3, 7000);
        checkOutput("full_finish_cycle", cyc, 6145);
        checkOutput("full_reads",  rd_count, 4096);
        checkOutput("full_writes", wr_count, 1024);
        checkOutput("full_no_clash", port_clash, 0);
        for (int i = 0; i < 1024; i++)
            checkOutput($sformatf("full_m1_%0d", i), m1[i], gold[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/conv_maxpool.md
# conv_maxpool

Downstream pooling stage for the `conv` engine. After `conv` finishes, this block reads its feature map from the shared output BRAM and performs 2x2, stride-2 signed max pooling with optional ReLU. It writes the pooled map to a second `bram_sim` instance and raises `finish`. It uses the same start/finish and BRAM request protocol as `conv`, so both stages can be chained by a controller or bench.

## Interface
Parameters:
- `IMG_W`, 64: input feature-map width in words; must be even, ≥2.
- `IMG_H`, 64: input feature-map height in words; must be even, ≥2.
- `IN_BASE`, 0: word address of input pixel (0,0) in the source BRAM.
- `OUT_BASE`, 0: word address of output pixel (0,0) in the destination BRAM.
- `RELU`, 0: when 1, negative maxima are written as 0.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a pooling pass; sampled only in IDLE.
- `finish`  out  1  high when a pass is complete; held until the next accepted `start` or `rst`.
- `M0_R_req`  out  1  source BRAM read request.
- `M0_addr`  out  32  source BRAM word address.
- `M0_R_data`  in  32  source read data; valid the cycle after `M0_R_req`.
- `M0_W_req`  out  4  source byte write enables; tied 0.
- `M0_W_data`  out  32  tied 0.
- `M1_R_req`  out  1  destination read request; tied 0.
- `M1_addr`  out  32  destination BRAM word address.
- `M1_R_data`  in  32  unused.
- `M1_W_req`  out  4  destination byte write enables; 4'hF writes a full word.
- `M1_W_data`  out  32  pooled value.

## Operation
- **Output grid:** OW = IMG_W/2, OH = IMG_H/2, N = OW·OH. Output (oy,ox) is visited in raster order, ox fastest.
- **Window element k (0..3):** address = IN_BASE + (2·oy + k[1])·IMG_W + 2·ox + k[0]. Order is top-left, top-right, bottom-left, bottom-right.
- **Max rule:** signed 32-bit compare. The running max is initialised with element 0. Ties keep the existing value, which is numerically identical. No saturation or width growth.
- **ReLU:** if RELU=1 and max[31]=1, the written value is 32'h0.
- **Output address:** OUT_BASE + oy·OW + ox.
- **FSM states:**
  - IDLE: `start`=1 → RD, with k=0, ox=oy=0, `finish`←0.
  - RD (k=0..3): issue `M0_R_req`=1 with the element-k address. On k=3 → LAST.
  - LAST: no request. Capture element 3 and finalise the max. → WR.
  - WR: drive `M1_W_req`=4'hF with output address and data for one cycle.
    - If the window was the last one → DONE.
    - Otherwise advance (ox, oy) and → RD with k=0.
  - DONE: `finish`=1 → IDLE. `finish` stays high while in IDLE.
- **Data capture:** `M0_R_data` is captured in the cycle after each read, i.e. in RD k=1..3 and in LAST.
- **start handling:** `start` outside IDLE is ignored. `start` in IDLE with `finish` high begins a new pass and clears `finish`.
- **Reset:** `rst` at any time, including mid-pass, forces IDLE and clears counters and the running max. No further BRAM writes occur. Words already written to M1 are left as-is.

## Timing
- **Reset values:**
  - `finish`=0, `M0_R_req`=0, `M1_W_req`=0.
  - `M0_addr`=0, `M1_addr`=0, `M1_W_data`=0.
  - Tied outputs are 0.
- **Idle outputs:** outside their active states, request lines are 0 and address/data hold their last value.
- **Per-window cycle pattern (cycle 1 = first cycle after the edge that samples `start`):**
  - Cycles 1–4: RD k0..k3.
  - Cycle 5: LAST.
  - Cycle 6: WR.
  - Window j's write occurs in cycle 6j+6.
- **Completion:** the last write is in cycle 6N; `finish` rises in cycle 6N+1. For 64x64 that is cycle 6145.
- **Port activity:** at most one M0 read and at most one M1 write per cycle; M0 and M1 are never both active in the same cycle.
- **Back-to-back passes:** `start` in the first IDLE cycle after DONE is accepted.

## Test plan
- **4x4 ramp:** IMG_W=IMG_H=4, M0[i]=i for i=0..15, start.
  - M1[0..3] = 5, 7, 13, 15.
  - `finish` rises in cycle 25.
- **Signed compare:** window = {FFFFFFFE, FFFFFFFF, 80000000, FFFFFFF0}.
  - RELU=0 → FFFFFFFF.
  - RELU=1 → 00000000.
  - A window containing 7FFFFFFF and 80000000 → 7FFFFFFF.
- **Address walk:** IMG_W=8, IMG_H=4, IN_BASE=100, OUT_BASE=50.
  - Read address sequence begins 100, 101, 108, 109, 102, 103, 110, 111.
  - Writes go to 50..57 only; M1[49] and M1[58] stay untouched.
- **start while busy / re-start:**
  - Pulse `start` in cycle 10 → ignored; the pass ends on the nominal cycle.
  - Pulse `start` right after `finish` → `finish` drops the next cycle and a second identical pass completes.
- **Reset mid-pass:** assert `rst` at cycle 20 of a 4x4 pass.
  - All requests are 0 the next cycle and `finish`=0.
  - Only M1[0..2] are written.
  - A subsequent `start` produces the full correct result.
- **Full 64x64:** random signed data vs. a software golden model.
  - All 1024 words match.
  - `finish` at cycle 6145.
  - Exactly 4096 reads and 1024 writes counted.
